// File: rtl/lfsr_pkg.sv
// Shared types and the single-shift helper for the LFSR stream generator.
// The helper works on a 64-bit container so one function serves every WIDTH.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } lfsr_state_e;

  // Bits at and above 'width' must be zero on entry; they stay zero on exit.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_shift1(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] r;
    logic                  fb;
    fb = ^(state & taps);
    r = state >> 1;
    r[width-1] = fb;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_next_n.sv
// Combinational STEP-fold unrolling of the Fibonacci single shift.
module lfsr_next_n
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 20,
  parameter logic [WIDTH-1:0] TAPS = 20'h08881,
  parameter int              STEP  = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  always_comb begin
    state_o = state_i;
    for (int i = 0; i < STEP; i++) begin
      state_o = WIDTH'(lfsr_shift1(LFSR_MAX_W'(state_o), LFSR_MAX_W'(TAPS), WIDTH));
    end
  end

endmodule

// File: rtl/lfsr_stream_gen.sv
// LFSR pseudo-random stream with seed load, hold, zero-seed guard and
// period-wrap detection. All outputs come straight from flops.
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 20,
  parameter logic [WIDTH-1:0] TAPS      = 20'h08881,
  parameter int               STEP      = 1,
  parameter logic [WIDTH-1:0] SEED_INIT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             seed_ready,
  input  logic             hold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] step_cnt,
  output logic             wrap,
  output logic             zero_seed
);

  // A zero state would lock the LFSR, so zero seeds are replaced by 1.
  localparam logic [WIDTH-1:0] INIT_STATE = (SEED_INIT == '0) ? WIDTH'(1) : SEED_INIT;
  localparam lfsr_state_e      INIT_FSM   = (SEED_INIT == '0) ? IDLE : RUN;

  lfsr_state_e      fsm_q, fsm_d;
  logic             out_valid_q, out_valid_d;
  logic             seed_ready_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic             wrap_q, wrap_d;
  logic             zero_seed_q, zero_seed_d;
  logic [WIDTH-1:0] state_adv;
  logic             seed_load;
  logic             xfer;

  // Handshakes: a beat moves only when valid and ready are both high at the
  // clock edge; valid never depends on ready, and a seed load wins over a
  // transfer in the same cycle (the transfer is dropped).
  assign seed_load = seed_valid & seed_ready_q;
  assign xfer      = out_valid_q & out_ready;

  lfsr_next_n #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_next (
    .state_i (state_q),
    .state_o (state_adv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= INIT_FSM;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    fsm_d = IDLE;
      RUN:     if (hold) fsm_d = HOLD;
      HOLD:    if (!hold) fsm_d = RUN;
      default: fsm_d = IDLE;
    endcase
    if (seed_load) begin
      fsm_d = hold ? HOLD : RUN;
    end
  end

  always_comb begin
    out_valid_d = (fsm_d == RUN);
  end

  always_comb begin
    state_d     = state_q;
    seed_reg_d  = seed_reg_q;
    step_cnt_d  = step_cnt_q;
    wrap_d      = 1'b0;
    zero_seed_d = zero_seed_q;
    if (seed_load) begin
      state_d    = (seed == '0) ? WIDTH'(1) : seed;
      seed_reg_d = state_d;
      step_cnt_d = '0;
      if (seed == '0) zero_seed_d = 1'b1;
    end else if (xfer) begin
      state_d = state_adv;
      if (state_adv == seed_reg_q) begin
        step_cnt_d = '0;
        wrap_d     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= (INIT_FSM == RUN);
      seed_ready_q <= 1'b0;
      state_q      <= INIT_STATE;
      seed_reg_q   <= INIT_STATE;
      step_cnt_q   <= '0;
      wrap_q       <= 1'b0;
      zero_seed_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      seed_ready_q <= 1'b1;
      state_q      <= state_d;
      seed_reg_q   <= seed_reg_d;
      step_cnt_q   <= step_cnt_d;
      wrap_q       <= wrap_d;
      zero_seed_q  <= zero_seed_d;
    end
  end

  assign seed_ready = seed_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = state_q;
  assign step_cnt   = step_cnt_q;
  assign wrap       = wrap_q;
  assign zero_seed  = zero_seed_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: three configurations driven in lockstep against
// an abstract stream model, plus hand-computed literal expectations.
module tb_lfsr_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_valid;
  logic        hold;
  logic        out_ready;
  logic [19:0] seed20;
  logic [3:0]  seed4;

  logic        d_srdy, d_vld, d_wrap, d_zs;
  logic [19:0] d_data, d_cnt;
  logic        a_srdy, a_vld, a_wrap, a_zs;
  logic [3:0]  a_data, a_cnt;
  logic        b_srdy, b_vld, b_wrap, b_zs;
  logic [3:0]  b_data, b_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  lfsr_stream_gen u_def (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed20), .seed_ready(d_srdy),
    .hold(hold), .out_valid(d_vld), .out_ready(out_ready), .out_data(d_data),
    .step_cnt(d_cnt), .wrap(d_wrap), .zero_seed(d_zs)
  );

  lfsr_stream_gen #(.WIDTH(4), .TAPS(4'h3), .STEP(1), .SEED_INIT(4'h1)) u_w4 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed4), .seed_ready(a_srdy),
    .hold(hold), .out_valid(a_vld), .out_ready(out_ready), .out_data(a_data),
    .step_cnt(a_cnt), .wrap(a_wrap), .zero_seed(a_zs)
  );

  lfsr_stream_gen #(.WIDTH(4), .TAPS(4'h3), .STEP(3), .SEED_INIT(4'h0)) u_s3 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed4), .seed_ready(b_srdy),
    .hold(hold), .out_valid(b_vld), .out_ready(out_ready), .out_data(b_data),
    .step_cnt(b_cnt), .wrap(b_wrap), .zero_seed(b_zs)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] st;
    logic [63:0] sr;
    logic [63:0] cnt;
    bit          active;
    bit          vld;
    bit          wrap;
    bit          zs;
    bit          srdy;
  } mdl_t;

  mdl_t m_def, m_w4, m_s3;

  function automatic logic [63:0] model_shift(logic [63:0] s, logic [63:0] taps, int w);
    int ones = 0;
    for (int i = 0; i < w; i++) if (s[i] && taps[i]) ones++;
    return (s >> 1) | (64'(ones % 2) << (w - 1));
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int w, logic [63:0] taps, int step,
                                    logic [63:0] init, bit r, bit sv, logic [63:0] sd,
                                    bit hd, bit ordy);
    mdl_t        n;
    logic [63:0] s;
    n = m;
    if (r) begin
      n.st = (init == 0) ? 64'd1 : init;
      n.sr = n.st;
      n.cnt = 0;
      n.active = (init != 0);
      n.vld = n.active;
      n.wrap = 0;
      n.zs = 0;
      n.srdy = 0;
      return n;
    end
    n.wrap = 0;
    n.srdy = 1;
    if (sv && m.srdy) begin
      n.st = (sd == 0) ? 64'd1 : sd;
      n.sr = n.st;
      n.cnt = 0;
      if (sd == 0) n.zs = 1;
      n.active = 1;
    end else if (m.vld && ordy) begin
      s = m.st;
      for (int i = 0; i < step; i++) s = model_shift(s, taps, w);
      n.st = s;
      if (s == m.sr) begin
        n.cnt = 0;
        n.wrap = 1;
      end else begin
        n.cnt = (m.cnt + 1) & ((64'd1 << w) - 1);
      end
    end
    n.vld = n.active && !hd;
    return n;
  endfunction

  always @(posedge clk) begin
    m_def = mdl_next(m_def, 20, 64'h08881, 1, 64'h1, rst, seed_valid, 64'(seed20), hold, out_ready);
    m_w4  = mdl_next(m_w4,  4,  64'h3,     1, 64'h1, rst, seed_valid, 64'(seed4),  hold, out_ready);
    m_s3  = mdl_next(m_s3,  4,  64'h3,     3, 64'h0, rst, seed_valid, 64'(seed4),  hold, out_ready);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_dut(input string tag, input logic srdy, input logic vld,
                         input logic [63:0] data, input logic [63:0] cnt,
                         input logic wrp, input logic zs, input mdl_t m);
    check({tag, ".seed_ready"}, 64'(srdy), 64'(m.srdy));
    check({tag, ".out_valid"},  64'(vld),  64'(m.vld));
    check({tag, ".out_data"},   data,      m.st);
    check({tag, ".step_cnt"},   cnt,       m.cnt);
    check({tag, ".wrap"},       64'(wrp),  64'(m.wrap));
    check({tag, ".zero_seed"},  64'(zs),   64'(m.zs));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("def", d_srdy, d_vld, 64'(d_data), 64'(d_cnt), d_wrap, d_zs, m_def);
      cmp_dut("w4",  a_srdy, a_vld, 64'(a_data), 64'(a_cnt), a_wrap, a_zs, m_w4);
      cmp_dut("s3",  b_srdy, b_vld, 64'(b_data), 64'(b_cnt), b_wrap, b_zs, m_s3);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [19:0] def_seq [4];
  logic [19:0] frozen;

  initial begin
    def_seq[0] = 20'h00001;
    def_seq[1] = 20'h80000;
    def_seq[2] = 20'h40000;
    def_seq[3] = 20'h20000;
    rst = 1'b1; seed_valid = 1'b0; hold = 1'b0; out_ready = 1'b0;
    seed20 = '0; seed4 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.def_valid", 64'(d_vld), 64'd1);
    check("rst.def_data", 64'(d_data), 64'h1);
    check("rst.s3_idle_valid", 64'(b_vld), 64'd0);
    check("rst.s3_data", 64'(b_data), 64'h1);
    check("rst.seed_ready", 64'(d_srdy), 64'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.seed_ready", 64'(d_srdy), 64'd1);

    // Seed 1 everywhere and stream continuously.
    seed20 = 20'h00001; seed4 = 4'h1; seed_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      seed_valid = 1'b0;
      if (k < 4) begin
        check($sformatf("seq.def_data%0d", k), 64'(d_data), 64'(def_seq[k]));
        check($sformatf("seq.def_cnt%0d", k), 64'(d_cnt), 64'(k));
      end
      if (k == 14) check("w4.cnt_before_wrap", 64'(a_cnt), 64'd14);
      if (k == 15 || k == 30) begin
        check("w4.wrap_pulse", 64'(a_wrap), 64'd1);
        check("w4.wrap_data", 64'(a_data), 64'h1);
        check("w4.wrap_cnt", 64'(a_cnt), 64'd0);
      end
      if (k == 5 || k == 10) begin
        check("s3.wrap_pulse", 64'(b_wrap), 64'd1);
        check("s3.wrap_data", 64'(b_data), 64'h1);
      end
    end

    // Hold for three cycles while out_ready toggles.
    hold = 1'b1;
    @(negedge clk);
    frozen = d_data;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      out_ready = ~out_ready;
      check("hold.def_valid", 64'(d_vld), 64'd0);
      check("hold.def_frozen", 64'(d_data), 64'(frozen));
    end
    hold = 1'b0;
    @(negedge clk);
    check("hold.released", 64'(d_vld), 64'd1);
    for (int k = 0; k < 8; k++) begin
      out_ready = (k % 3) != 0;
      @(negedge clk);
    end

    // Zero seed, then a seed load colliding with a transfer.
    out_ready = 1'b1; seed20 = '0; seed4 = '0; seed_valid = 1'b1;
    @(negedge clk);
    check("zero.def_data", 64'(d_data), 64'h1);
    check("zero.def_flag", 64'(d_zs), 64'd1);
    seed20 = 20'hABCDE; seed4 = 4'h9;
    @(negedge clk);
    seed_valid = 1'b0;
    check("collide.def_data", 64'(d_data), 64'hABCDE);
    check("collide.def_cnt", 64'(d_cnt), 64'd0);
    check("collide.zero_sticky", 64'(d_zs), 64'd1);
    repeat (5) @(negedge clk);

    // Reset mid-stream.
    rst = 1'b1;
    @(negedge clk);
    check("midrst.def_data", 64'(d_data), 64'h1);
    check("midrst.def_cnt", 64'(d_cnt), 64'd0);
    check("midrst.zero_clr", 64'(d_zs), 64'd0);
    check("midrst.s3_valid", 64'(b_vld), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
